// File: rtl/vdp_super_high_res_writer.sv
// Super high-res VRAM writer: packs CPU bytes into super_color / super_mid words and queues them for the arbiter.
// Build option VDP_SUPER_HIGH_RES_FLUSH_EN: an address write mid-word pushes the zero-filled partial word first.
module vdp_super_high_res_writer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vdp_super,
  input  logic        super_color,
  input  logic        super_mid,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_port,
  input  logic [7:0]  cpu_data,
  output logic        cpu_busy,
  output logic        overflow,
  output logic        vram_wr_req,
  output logic [16:0] vram_wr_addr,
  output logic [31:0] vram_wr_data,
  input  logic        vram_wr_ack
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [16:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        push_entry;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q;
  logic [CW-1:0] count_q, count_d, remain;
  logic [16:0]   ptr_q, ptr_d, addr_base;
  logic [1:0]    byte_cnt_q, byte_cnt_d, cnt_eff, last_byte, lane;
  logic [31:0]   asm_q, asm_d, asm_eff, word;
  logic          color_q, mid_q;
  logic          active, mode_chg, pop, push, can_push, overflow_d;

  // Byte assembly, pointer update and push decision
  always_comb begin
    active     = vdp_super & (super_color | super_mid);
    mode_chg   = (super_color != color_q) | (super_mid != mid_q);
    cnt_eff    = mode_chg ? 2'd0 : byte_cnt_q;
    asm_eff    = mode_chg ? 32'd0 : asm_q;
    last_byte  = super_color ? 2'd2 : 2'd3;
    lane       = last_byte - cnt_eff;
    pop        = vram_wr_req & vram_wr_ack;
    can_push   = (count_q != CW'(FIFO_DEPTH)) | pop;
    word       = asm_eff;
    addr_base  = ptr_q;
    push       = 1'b0;
    push_entry = '0;
    ptr_d      = ptr_q;
    byte_cnt_d = cnt_eff;
    asm_d      = asm_eff;
    overflow_d = overflow;

    case (lane)
      2'd0:    word[7:0]   = cpu_data;
      2'd1:    word[15:8]  = cpu_data;
      2'd2:    word[23:16] = cpu_data;
      default: word[31:24] = cpu_data;
    endcase

    if (cpu_wr) begin
      if (cpu_port != 2'd3) begin
`ifdef VDP_SUPER_HIGH_RES_FLUSH_EN
        if (cnt_eff != 2'd0) begin
          if (can_push) begin
            push       = 1'b1;
            push_entry = '{addr: ptr_q, data: asm_eff};
            addr_base  = ptr_q + 17'd2;
          end else begin
            overflow_d = 1'b1;
          end
        end
`endif
        ptr_d = addr_base;
        case (cpu_port)
          2'd0:    ptr_d[7:0]  = cpu_data;
          2'd1:    ptr_d[15:8] = cpu_data;
          default: ptr_d[16]   = cpu_data[0];
        endcase
        byte_cnt_d = 2'd0;
        asm_d      = 32'd0;
      end else if (active) begin
        if (cnt_eff == last_byte) begin
          // A dropped completing byte leaves the assembly intact so a retry finishes the word
          if (can_push) begin
            push       = 1'b1;
            push_entry = '{addr: ptr_q, data: word};
            ptr_d      = ptr_q + 17'd2;
            byte_cnt_d = 2'd0;
            asm_d      = 32'd0;
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          byte_cnt_d = cnt_eff + 2'd1;
          asm_d      = word;
        end
      end
    end

    count_d  = count_q + CW'(push) - CW'(pop);
    remain   = count_q - CW'(pop);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

  // Head is presented one cycle after it is written, from entries that survive this edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= 17'd0;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 32'd0;
      color_q      <= 1'b0;
      mid_q        <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      overflow     <= 1'b0;
      cpu_busy     <= 1'b0;
      vram_wr_req  <= 1'b0;
      vram_wr_addr <= 17'd0;
      vram_wr_data <= 32'd0;
    end else begin
      ptr_q       <= ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      color_q     <= super_color;
      mid_q       <= super_mid;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_q + PW'(push);
      overflow    <= overflow_d;
      cpu_busy    <= (count_d == CW'(FIFO_DEPTH));
      vram_wr_req <= (remain != '0);
      if (remain != '0) begin
        vram_wr_addr <= mem[rd_ptr_d].addr;
        vram_wr_data <= mem[rd_ptr_d].data;
      end
    end
  end
endmodule

// File: doc/vdp_super_high_res_writer.md
Name: vdp_super_high_res_writer

Overview:
Host-side writer for super high-res VRAM. It takes CPU byte writes on a small register port, packs them into 32-bit words in the super_color or super_mid pixel format, and queues address/data pairs in a FIFO. It presents queued words to the VRAM arbiter over a req/ack write handshake. It is the write-side counterpart of the super high-res scan-out path: same word layout, same 17-bit address space, address advancing by 2 per 32-bit word.

Parameters:
FIFO_DEPTH, 4, number of queued {address, data} entries; power of two, minimum 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
vdp_super  input  1  super mode enable
super_color  input  1  24-bit RGB word format
super_mid  input  1  16-bit GGGGGGRRRRRBBBBB two-pixel word format
cpu_wr  input  1  one-cycle write strobe
cpu_port  input  2  0 = addr[7:0], 1 = addr[15:8], 2 = addr[16] (bit 0 used), 3 = data byte
cpu_data  input  8  write data
cpu_busy  output  1  FIFO full
overflow  output  1  sticky: a data byte was dropped; cleared only by reset
vram_wr_req  output  1  write request
vram_wr_addr  output  17  word address (even)
vram_wr_data  output  32  word data
vram_wr_ack  input  1  arbiter accepted the current head entry

Behaviour:
- Reset is asynchronous and active-high. On reset: FIFO empty, vram_wr_req=0, vram_wr_addr=0, vram_wr_data=0, cpu_busy=0, overflow=0, write pointer=0, byte counter=0, assembly register=0. A reset mid-transaction abandons any pending request; no ack is awaited.
- active = vdp_super & (super_color | super_mid). super_color takes priority if both are set.
- Address writes (ports 0-2) update the matching bits of the write pointer and reset the byte counter to 0. Any partial word is discarded; see the optional feature for the alternative. Address writes are accepted whether or not active is set.
- Port 3 writes while active is clear are ignored and leave the byte counter unchanged.
- super_color packing: bytes R, G, B in order → word {8'h00, R, G, B}. The word completes on the 3rd byte.
- super_mid packing: bytes b0..b3 → word {b0, b1, b2, b3}. The first pixel lands in [31:16], high byte first. The word completes on the 4th byte.
- On word completion:
  - push {pointer, word} into the FIFO;
  - pointer advances by 2, 17-bit wrap (1FFFE → 00000);
  - byte counter returns to 0.
- If the FIFO is full on the completing byte, that byte is dropped and overflow is set. The byte counter and the assembly register stay unchanged, so a retry of the byte completes the word. Non-completing bytes are always accepted.
- cpu_busy = FIFO count == FIFO_DEPTH, registered from the next-state count.
- Drain handshake:
  - vram_wr_req is high whenever the FIFO is non-empty.
  - vram_wr_addr and vram_wr_data show the head entry and stay stable while req=1 and ack=0.
  - The head is popped on the clock edge where req & ack.
  - Ack while req=0 is ignored.
- A push and a pop in the same cycle leave the count unchanged. That push is accepted even when the FIFO is full. Back-to-back acks drain one entry per cycle.
- Mode bits changing mid-word: the byte counter is cleared on any change of super_color or super_mid. Queued entries still drain.
- Latency: completing cpu_wr at edge N → vram_wr_req=1 after edge N+1 when the FIFO was empty.

Optional Feature:
Macro: VDP_SUPER_HIGH_RES_FLUSH_EN
- Defined: an address write (any of ports 0-2) while the byte counter is non-zero first pushes the partial word at the old pointer, with unwritten bytes zero-filled. The old pointer then advances by 2 and the address write is applied. If the FIFO is full, the partial word is dropped and overflow is set.
- Not defined: the partial word is discarded silently.

Test Plan:
- super_color, addr=0x00010, bytes 11,22,33 → one req with addr 0x00010, data 0x00112233; after ack the pointer is 0x00012.
- super_mid, bytes AB,CD,12,34 → data 0xABCD1234; 8 further bytes → addrs +2, +4, with one word per ack.
- Hold ack=0 and write 5 words (FIFO_DEPTH=4) → cpu_busy=1 after the 4th; 5th word's last byte dropped, overflow=1; retry of that byte after one ack is accepted, with correct data and address.
- Pointer at 0x1FFFE, complete a word → addr 0x1FFFE issued, next word at 0x00000.
- super_color, 2 bytes then addr write → nothing pushed (macro undefined); with macro, data 0x00RRGG00 pushed at the old pointer.
- Assert reset while req=1 with 3 entries queued → req=0, FIFO empty, overflow=0 immediately, without a clock edge; ack during reset has no effect.
